// File: rtl/fsm_trace_display.sv
// fsm_trace_display: captures the sequence-detector FSM debug bus, counts
// rising edges of its Moore and Mealy outputs, and scans current state,
// next state and both counts onto a 4-digit common-anode 7-segment display.
// Optional build macro: TRACE_SAT_EN (counters saturate at F instead of wrapping).
module fsm_trace_display #(
    parameter int unsigned REFRESH_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Q,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned EDGE_W = 2;

    logic [7:0]           q_r;
    logic [EDGE_W-1:0]    q_prev;      // only the Moore/Mealy bits need history
    logic                 armed;
    logic [CNT_W-1:0]     moore_cnt;
    logic [CNT_W-1:0]     mealy_cnt;
    logic [REFRESH_W-1:0] ref_cnt;

    logic                 inc_moore_c;
    logic                 inc_mealy_c;
    logic [CNT_W-1:0]     moore_nxt_c;
    logic [CNT_W-1:0]     mealy_nxt_c;
    logic [1:0]           sel_c;
    logic [CNT_W-1:0]     digit_val_c;
    logic [DIG_W-1:0]     an_nxt_c;
    logic                 dp_nxt_c;
    logic [SEG_W-1:0]     seg_nxt_c;

    // Active-low hex to {g,f,e,d,c,b,a}
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [CNT_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next value of a pulse counter; clear beats increment
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic clear);
        logic [CNT_W-1:0] n;
        n = cnt;
        if (clear) begin
            n = '0;
        end else if (inc) begin
`ifdef TRACE_SAT_EN
            if (cnt != {CNT_W{1'b1}}) begin
                n = cnt + CNT_W'(1);
            end
`else
            n = cnt + CNT_W'(1);
`endif
        end
        return n;
    endfunction

    // Bus capture; the first sample after reset seeds the history so it never counts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r    <= '0;
            q_prev <= '0;
            armed  <= 1'b0;
        end else begin
            q_r <= Q;
            if (!armed) begin
                q_prev <= Q[EDGE_W-1:0];
                armed  <= 1'b1;
            end else begin
                q_prev <= q_r[EDGE_W-1:0];
            end
        end
    end

    // Rising-edge detect and counter next-state
    always_comb begin
        inc_moore_c = armed & q_r[0] & ~q_prev[0];
        inc_mealy_c = armed & q_r[1] & ~q_prev[1];
        moore_nxt_c = cnt_next(moore_cnt, inc_moore_c, clr);
        mealy_nxt_c = cnt_next(mealy_cnt, inc_mealy_c, clr);
    end

    // Pulse counters and free-running refresh counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            moore_cnt <= '0;
            mealy_cnt <= '0;
            ref_cnt   <= '0;
        end else begin
            moore_cnt <= moore_nxt_c;
            mealy_cnt <= mealy_nxt_c;
            ref_cnt   <= ref_cnt + REFRESH_W'(1);
        end
    end

    // Digit select: pick value, anode and decimal point for the current slot
    always_comb begin
        sel_c       = ref_cnt[REFRESH_W-1 -: 2];
        digit_val_c = '0;
        an_nxt_c    = 4'b1111;
        dp_nxt_c    = 1'b1;
        case (sel_c)
            2'd0: begin
                digit_val_c = moore_cnt;
                an_nxt_c    = 4'b1110;
                dp_nxt_c    = ~q_r[0];
            end
            2'd1: begin
                digit_val_c = mealy_cnt;
                an_nxt_c    = 4'b1101;
                dp_nxt_c    = ~q_r[1];
            end
            2'd2: begin
                digit_val_c = {1'b0, q_r[4:2]};
                an_nxt_c    = 4'b1011;
            end
            default: begin
                digit_val_c = {1'b0, q_r[7:5]};
                an_nxt_c    = 4'b0111;
            end
        endcase
        seg_nxt_c = hex_to_seg(digit_val_c);
    end

    // Registered display outputs; anode and segments always update together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt_c;
            an  <= an_nxt_c;
            dp  <= dp_nxt_c;
        end
    end

endmodule

// File: tb/tb_fsm_trace_display.sv
// Directed bench for fsm_trace_display with REFRESH_W=4.
module tb_fsm_trace_display;

    logic       clk;
    logic       reset;
    logic [7:0] Q;
    logic       clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int errors = 0;
    int checks = 0;
    int exp_moore = 0;
    int exp_mealy = 0;

    logic [6:0] hex_tab [16];
    logic [3:0] an_s [64];
    logic       dp_s [64];
    logic       qd   [64];

    fsm_trace_display #(.REFRESH_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .Q    (Q),
        .clr  (clr),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a digit to be lit, then check its segments and dp
    task automatic show(input string tag, input logic [3:0] an_t,
                        input logic [6:0] seg_e, input logic dp_e);
        int n = 0;
        while (an !== an_t && n < 40) begin
            tick();
            n++;
        end
        if (an !== an_t) begin
            check({tag, "_timeout"}, 32'(an), 32'(an_t));
        end else begin
            check({tag, "_seg"}, 32'(seg), 32'(seg_e));
            check({tag, "_dp"}, 32'(dp), 32'(dp_e));
        end
    endtask

    // One 2-cycle-wide pulse on Q[0] (optionally Q[1]), checking 2-cycle latency
    task automatic pulse(input string tag, input logic with_mealy);
        int nm;
        Q = with_mealy ? 8'b000_000_11 : 8'b000_000_01;
        tick();
        check({tag, "_pre"}, 32'(dut.moore_cnt), 32'(exp_moore));
`ifdef TRACE_SAT_EN
        nm = (exp_moore == 15) ? 15 : exp_moore + 1;
`else
        nm = (exp_moore + 1) % 16;
`endif
        exp_moore = nm;
        if (with_mealy) exp_mealy = (exp_mealy + 1) % 16;
        tick();
        check({tag, "_moore"}, 32'(dut.moore_cnt), 32'(exp_moore));
        check({tag, "_mealy"}, 32'(dut.mealy_cnt), 32'(exp_mealy));
        Q = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
        hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
        hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
        hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
        hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
        hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
        hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
        hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;

        reset = 1'b0;
        Q     = 8'h00;
        clr   = 1'b0;
        tick();
        tick();
        check("por_seg", 32'(seg), 32'h7F);
        check("por_an", 32'(an), 32'hF);
        check("por_dp", 32'(dp), 32'h1);

        // Count to 5, then reset asynchronously between edges
        reset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) pulse("pre_rst", 1'b0);
        check("cnt5", 32'(dut.moore_cnt), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_moore", 32'(dut.moore_cnt), 32'd0);
        check("rst_mealy", 32'(dut.mealy_cnt), 32'd0);
        exp_moore = 0;
        exp_mealy = 0;

        // First sample after reset already Moore-high: must not count
        Q = 8'b100_000_01;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("first_moore", 32'(dut.moore_cnt), 32'd0);
        show("dig3_state", 4'b0111, hex_tab[4], 1'b1);
        show("dig0_first", 4'b1110, hex_tab[0], 1'b0);

        // Three pulses, Mealy rising with the second
        Q = 8'h00;
        tick();
        tick();
        check("drop_moore", 32'(dut.moore_cnt), 32'd0);
        pulse("p1", 1'b0);
        pulse("p2", 1'b1);
        pulse("p3", 1'b0);
        check("cnt_moore3", 32'(dut.moore_cnt), 32'd3);
        check("cnt_mealy1", 32'(dut.mealy_cnt), 32'd1);
        show("dig0_cnt", 4'b1110, hex_tab[3], 1'b1);
        show("dig1_cnt", 4'b1101, hex_tab[1], 1'b1);

        // Clear, then 17 Moore pulses for wrap/saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_moore = 0;
        exp_mealy = 0;
        check("clr_moore", 32'(dut.moore_cnt), 32'd0);
        check("clr_mealy", 32'(dut.mealy_cnt), 32'd0);
        for (int i = 0; i < 17; i++) pulse("wrap", 1'b0);
`ifdef TRACE_SAT_EN
        check("wrap_final", 32'(dut.moore_cnt), 32'hF);
`else
        check("wrap_final", 32'(dut.moore_cnt), 32'h1);
`endif
        show("dig0_wrap", 4'b1110, hex_tab[exp_moore], 1'b1);

        // Clear coincident with a Mealy edge
        Q = 8'b000_000_10;
        tick();
        tick();
        check("mealy_up", 32'(dut.mealy_cnt), 32'd1);
        Q = 8'h00;
        tick();
        tick();
        Q = 8'b000_000_10;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clrpri_mealy", 32'(dut.mealy_cnt), 32'd0);
        check("clrpri_moore", 32'(dut.moore_cnt), 32'd0);
        tick();
        tick();
        tick();
        check("clrpri_hold", 32'(dut.mealy_cnt), 32'd0);
        Q = 8'h00;
        tick();

        // Scan: 64 free-running clocks with Q[0] toggling every 3 cycles
        for (int i = 0; i < 64; i++) begin
            qd[i] = ((i / 3) % 2) == 1;
            Q = {7'b0, qd[i]};
            tick();
            an_s[i] = an;
            dp_s[i] = dp;
        end
        begin
            int c = 0;
            logic [3:0] ea;
            for (int i = 63; i >= 1; i--) if (an_s[i] != an_s[i-1]) c = i;
            check("scan_phase", 32'(c >= 1 && c <= 4), 32'd1);
            ea = 4'b1110;
            if (an_s[c] == 4'b1101) ea = 4'b1101;
            if (an_s[c] == 4'b1011) ea = 4'b1011;
            if (an_s[c] == 4'b0111) ea = 4'b0111;
            for (int i = c; i < 64; i++) begin
                if (i > c && ((i - c) % 4) == 0) ea = {ea[2:0], ea[3]};
                check($sformatf("scan_an%0d", i), 32'(an_s[i]), 32'(ea));
            end
            for (int i = 1; i < 64; i++) begin
                logic ed;
                ed = (an_s[i] == 4'b1110) ? ~qd[i-1] : 1'b1;
                check($sformatf("scan_dp%0d", i), 32'(dp_s[i]), 32'(ed));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
